// File: rtl/gpio_pkg.sv
// Register map shared by the GPIO interrupt block: offsets from the base address.
package gpio_pkg;
   localparam int unsigned NUM_REGS = 9;

   localparam logic [7:0] OFS_DIR     = 8'd0;
   localparam logic [7:0] OFS_PORT    = 8'd1;
   localparam logic [7:0] OFS_PINS    = 8'd2;
   localparam logic [7:0] OFS_SET     = 8'd3;
   localparam logic [7:0] OFS_CLR     = 8'd4;
   localparam logic [7:0] OFS_TGL     = 8'd5;
   localparam logic [7:0] OFS_RISE_EN = 8'd6;
   localparam logic [7:0] OFS_FALL_EN = 8'd7;
   localparam logic [7:0] OFS_PEND    = 8'd8;
endpackage

// File: rtl/gpio_sync.sv
// Pad synchronizer chain plus one-cycle-delayed copy for rise/fall detection.
module gpio_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
   logic [WIDTH-1:0]                  prev_q, prev_d;

   always_comb begin
      chain_d    = chain_q;
      chain_d[0] = pins_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         chain_d[s] = chain_q[s-1];
      end
      prev_d = chain_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
         prev_q  <= '0;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
      end
   end

   assign sync = chain_q[SYNC_STAGES-1];
   assign rise = sync & ~prev_q;
   assign fall = ~sync & prev_q;
endmodule

// File: rtl/gpio_irq.sv
// GPIO port with direction control, atomic set/clear/toggle, and edge-triggered
// pending bits that combine into a registered interrupt request.
module gpio_irq
   import gpio_pkg::*;
#(
   parameter logic [7:0] GPIO_ADDRESS = 8'h00,
   parameter int         WIDTH        = 8,
   parameter int         SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       din,
   input  logic [7:0]       address,
   input  logic             w_en,
   input  logic             r_en,
   output logic [7:0]       dout,
   output logic             irq,
   inout  wire  [WIDTH-1:0] pins
);
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] port_q, port_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [7:0]       dout_q, dout_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] pin_sync, pin_rise, pin_fall;
   logic [WIDTH-1:0] wdata, pend_clr;
   logic [7:0]       rdata;
   logic [8:0]       ofs;
   logic             mapped;

   gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .pins_in (pins),
      .sync    (pin_sync),
      .rise    (pin_rise),
      .fall    (pin_fall)
   );

   // Nine-bit subtraction so addresses below the base wrap far out of range.
   assign ofs    = {1'b0, address} - {1'b0, GPIO_ADDRESS};
   assign mapped = (ofs < 9'(NUM_REGS));
   assign wdata  = din[WIDTH-1:0];

   always_comb begin
      rdata = '0;
      case (ofs)
         {1'b0, OFS_DIR}:     rdata[WIDTH-1:0] = dir_q;
         {1'b0, OFS_PORT}:    rdata[WIDTH-1:0] = port_q;
         {1'b0, OFS_PINS}:    rdata[WIDTH-1:0] = pin_sync;
         {1'b0, OFS_RISE_EN}: rdata[WIDTH-1:0] = rise_en_q;
         {1'b0, OFS_FALL_EN}: rdata[WIDTH-1:0] = fall_en_q;
         {1'b0, OFS_PEND}:    rdata[WIDTH-1:0] = pend_q;
         default:             rdata = '0;
      endcase
   end

   always_comb begin
      dir_d     = dir_q;
      port_d    = port_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      pend_clr  = '0;
      dout_d    = dout_q;

      if (r_en && mapped) begin
         dout_d = rdata;
      end

      if (w_en) begin
         case (ofs)
            {1'b0, OFS_DIR}:     dir_d     = wdata;
            {1'b0, OFS_PORT}:    port_d    = wdata;
            {1'b0, OFS_SET}:     port_d    = port_q | wdata;
            {1'b0, OFS_CLR}:     port_d    = port_q & ~wdata;
            {1'b0, OFS_TGL}:     port_d    = port_q ^ wdata;
            {1'b0, OFS_RISE_EN}: rise_en_d = wdata;
            {1'b0, OFS_FALL_EN}: fall_en_d = wdata;
            {1'b0, OFS_PEND}:    pend_clr  = wdata;
            default:             ;
         endcase
      end

      // A new edge in the same cycle as a clear keeps the bit set.
      pend_d = (pend_q & ~pend_clr) | (pin_rise & rise_en_q) | (pin_fall & fall_en_q);
      irq_d  = |pend_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q     <= '0;
         port_q    <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pend_q    <= '0;
         dout_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         port_q    <= port_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pend_q    <= pend_d;
         dout_q    <= dout_d;
         irq_q     <= irq_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign pins[i] = dir_q[i] ? port_q[i] : 1'bz;
   end

   assign dout = dout_q;
   assign irq  = irq_q;
endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: register map, pad drive, edge interrupts, reset.
module tb_gpio_irq;
   localparam logic [7:0] BASE   = 8'h40;
   localparam logic [7:0] R_DIR  = 8'd0;
   localparam logic [7:0] R_PORT = 8'd1;
   localparam logic [7:0] R_PINS = 8'd2;
   localparam logic [7:0] R_SET  = 8'd3;
   localparam logic [7:0] R_CLR  = 8'd4;
   localparam logic [7:0] R_TGL  = 8'd5;
   localparam logic [7:0] R_RISE = 8'd6;
   localparam logic [7:0] R_FALL = 8'd7;
   localparam logic [7:0] R_PEND = 8'd8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] address = 8'h00;
   logic       w_en = 1'b0;
   logic       r_en = 1'b0;
   logic [7:0] dout;
   logic       irq;
   wire  [7:0] pins;
   logic [7:0] tb_oe = 8'h00;
   logic [7:0] tb_drv = 8'h00;

   int vectors = 0;
   int miscompares = 0;

   for (genvar i = 0; i < 8; i++) begin : g_tb_pad
      assign pins[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
   end

   always #5 clk = ~clk;

   gpio_irq #(
      .GPIO_ADDRESS (BASE),
      .WIDTH        (8),
      .SYNC_STAGES  (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din),
      .address (address),
      .w_en    (w_en),
      .r_en    (r_en),
      .dout    (dout),
      .irq     (irq),
      .pins    (pins)
   );

   // Bus tasks start and end on a falling edge.
   task automatic bus_write(input logic [7:0] ofs, input logic [7:0] data);
      address = BASE + ofs;
      din     = data;
      w_en    = 1'b1;
      @(negedge clk);
      w_en    = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] ofs, output logic [7:0] q);
      address = BASE + ofs;
      r_en    = 1'b1;
      @(negedge clk);
      r_en    = 1'b0;
      q       = dout;
   endtask

   task automatic bus_rw(input logic [7:0] ofs, input logic [7:0] data, output logic [7:0] q);
      address = BASE + ofs;
      din     = data;
      w_en    = 1'b1;
      r_en    = 1'b1;
      @(negedge clk);
      w_en    = 1'b0;
      r_en    = 1'b0;
      q       = dout;
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      logic [7:0] regs [5] = '{R_DIR, R_PORT, R_RISE, R_FALL, R_PEND};
      rst_n  = 1'b0;
      tb_oe  = 8'hFF;
      tb_drv = 8'h3C;
      @(negedge clk);
      vectors++;
      if (dout !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_dout: got %h expected 00", dout);
      end
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         bus_read(regs[i], rd);
         vectors++;
         if (rd !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_reg ofs %0d: got %h expected 00", regs[i], rd);
         end
      end
      bus_read(R_PINS, rd);
      vectors++;
      if (rd !== 8'h3C) begin
         miscompares++;
         $display("FAIL reset_pins: got %h expected 3c", rd);
      end
      // Pins already high at reset release must not leave anything pending.
      bus_write(R_RISE, 8'hFF);
      bus_write(R_FALL, 8'hFF);
      repeat (4) @(negedge clk);
      bus_read(R_PEND, rd);
      vectors++;
      if (rd !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_no_pend: got %h expected 00", rd);
      end
      bus_write(R_RISE, 8'h00);
      bus_write(R_FALL, 8'h00);
      tb_drv = 8'h00;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_pins_drive();
      logic [7:0] rd;
      logic [7:0] exp_pins [3] = '{8'h00, 8'h00, 8'hA5};
      bus_write(R_PORT, 8'hA5);
      bus_write(R_DIR, 8'hFF);
      tb_oe = 8'h00;
      for (int k = 0; k < 3; k++) begin
         bus_read(R_PINS, rd);
         vectors++;
         if (rd !== exp_pins[k]) begin
            miscompares++;
            $display("FAIL pins_sync_latency cycle %0d: got %h expected %h", k + 1, rd, exp_pins[k]);
         end
      end
      vectors++;
      if (pins !== 8'hA5) begin
         miscompares++;
         $display("FAIL pins_driven: got %h expected a5", pins);
      end
      bus_read(R_DIR, rd);
      vectors++;
      if (rd !== 8'hFF) begin
         miscompares++;
         $display("FAIL dir_readback: got %h expected ff", rd);
      end
   endtask

   task automatic test_set_clr_tgl();
      logic [7:0] rd;
      logic [7:0] ops      [3] = '{R_SET, R_CLR, R_TGL};
      logic [7:0] op_data  [3] = '{8'h0A, 8'h0F, 8'hFF};
      logic [7:0] exp_port [3] = '{8'hAF, 8'hA0, 8'h5F};
      for (int k = 0; k < 3; k++) begin
         bus_write(ops[k], op_data[k]);
         bus_read(R_PORT, rd);
         vectors++;
         if (rd !== exp_port[k]) begin
            miscompares++;
            $display("FAIL port_atomic op %0d: got %h expected %h", ops[k], rd, exp_port[k]);
         end
      end
      for (int k = 0; k < 3; k++) begin
         bus_read(R_PORT, rd);
         bus_read(ops[k], rd);
         vectors++;
         if (rd !== 8'h00) begin
            miscompares++;
            $display("FAIL wo_reads_zero ofs %0d: got %h expected 00", ops[k], rd);
         end
      end
      bus_rw(R_PORT, 8'h33, rd);
      vectors++;
      if (rd !== 8'h5F) begin
         miscompares++;
         $display("FAIL rw_pre_write_value: got %h expected 5f", rd);
      end
      bus_read(R_PORT, rd);
      vectors++;
      if (rd !== 8'h33) begin
         miscompares++;
         $display("FAIL rw_write_applied: got %h expected 33", rd);
      end
   endtask

   task automatic test_unmapped();
      logic [7:0] rd;
      logic [7:0] bad_addr [2] = '{BASE + 8'd9, BASE - 8'd1};
      logic [7:0] regs     [4] = '{R_DIR, R_PORT, R_RISE, R_FALL};
      logic [7:0] exp_regs [4] = '{8'hFF, 8'h33, 8'h00, 8'h00};
      bus_read(R_PORT, rd);
      for (int k = 0; k < 2; k++) begin
         address = bad_addr[k];
         din     = 8'hCC;
         w_en    = 1'b1;
         r_en    = 1'b1;
         @(negedge clk);
         w_en    = 1'b0;
         r_en    = 1'b0;
         vectors++;
         if (dout !== 8'h33) begin
            miscompares++;
            $display("FAIL unmapped_dout_held addr %h: got %h expected 33", bad_addr[k], dout);
         end
      end
      for (int k = 0; k < 4; k++) begin
         bus_read(regs[k], rd);
         vectors++;
         if (rd !== exp_regs[k]) begin
            miscompares++;
            $display("FAIL unmapped_no_change ofs %0d: got %h expected %h", regs[k], rd, exp_regs[k]);
         end
      end
   endtask

   task automatic test_rise_irq();
      logic [7:0] rd;
      logic [7:0] exp_dout [4] = '{8'h00, 8'h00, 8'h00, 8'h01};
      logic       exp_irq  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      tb_drv = 8'h33;
      tb_oe  = 8'hFF;
      bus_write(R_DIR, 8'h00);
      tb_drv = 8'h00;
      repeat (4) @(negedge clk);
      bus_write(R_RISE, 8'h01);
      bus_read(R_PEND, rd);
      vectors++;
      if (rd !== 8'h00) begin
         miscompares++;
         $display("FAIL rise_pend_idle: got %h expected 00", rd);
      end
      tb_drv  = 8'h01;
      address = BASE + R_PEND;
      r_en    = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vectors++;
         if (dout !== exp_dout[k] || irq !== exp_irq[k]) begin
            miscompares++;
            $display("FAIL rise_latency cycle %0d: got pend %h irq %b expected pend %h irq %b",
                     k + 1, dout, irq, exp_dout[k], exp_irq[k]);
         end
      end
      r_en = 1'b0;
      bus_write(R_PEND, 8'h01);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("FAIL irq_lags_clear: got %b expected 1", irq);
      end
      bus_read(R_PEND, rd);
      vectors++;
      if (rd !== 8'h00 || irq !== 1'b0) begin
         miscompares++;
         $display("FAIL pend_w1c: got pend %h irq %b expected pend 00 irq 0", rd, irq);
      end
   endtask

   task automatic test_fall_vs_clear();
      logic [7:0] rd;
      bus_write(R_FALL, 8'h80);
      tb_drv = 8'h81;
      repeat (4) @(negedge clk);
      bus_read(R_PEND, rd);
      vectors++;
      if (rd !== 8'h00) begin
         miscompares++;
         $display("FAIL fall_no_pend_on_rise: got %h expected 00", rd);
      end
      tb_drv = 8'h01;
      repeat (2) @(negedge clk);
      bus_write(R_PEND, 8'h80);
      bus_read(R_PEND, rd);
      vectors++;
      if (rd !== 8'h80 || irq !== 1'b1) begin
         miscompares++;
         $display("FAIL set_beats_clear: got pend %h irq %b expected pend 80 irq 1", rd, irq);
      end
      bus_write(R_FALL, 8'h00);
      bus_read(R_PEND, rd);
      vectors++;
      if (rd !== 8'h80) begin
         miscompares++;
         $display("FAIL pend_kept_on_disable: got %h expected 80", rd);
      end
      bus_write(R_PEND, 8'h80);
      bus_read(R_PEND, rd);
      vectors++;
      if (rd !== 8'h00) begin
         miscompares++;
         $display("FAIL pend7_clear: got %h expected 00", rd);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rd;
      logic [7:0] regs [4] = '{R_DIR, R_PORT, R_RISE, R_PEND};
      tb_drv = 8'h00;
      repeat (4) @(negedge clk);
      bus_write(R_PORT, 8'h00);
      bus_write(R_DIR, 8'hFF);
      tb_oe = 8'h00;
      bus_write(R_RISE, 8'h03);
      bus_write(R_PORT, 8'h03);
      repeat (5) @(negedge clk);
      bus_read(R_PEND, rd);
      vectors++;
      if (rd !== 8'h03 || irq !== 1'b1) begin
         miscompares++;
         $display("FAIL pend_from_outputs: got pend %h irq %b expected pend 03 irq 1", rd, irq);
      end
      @(posedge clk);
      #2;
      address = BASE + R_PORT;
      din     = 8'hFF;
      w_en    = 1'b1;
      #1;
      rst_n   = 1'b0;
      tb_oe   = 8'hFF;
      tb_drv  = 8'h5A;
      #1;
      vectors++;
      if (dout !== 8'h00 || irq !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset_outputs: got dout %h irq %b expected dout 00 irq 0", dout, irq);
      end
      vectors++;
      if (pins !== 8'h5A) begin
         miscompares++;
         $display("FAIL async_reset_pads_released: got %h expected 5a", pins);
      end
      w_en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_read(regs[k], rd);
         vectors++;
         if (rd !== 8'h00) begin
            miscompares++;
            $display("FAIL post_reset_reg ofs %0d: got %h expected 00", regs[k], rd);
         end
      end
      bus_read(R_PINS, rd);
      vectors++;
      if (rd !== 8'h5A || irq !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_pins: got pins %h irq %b expected pins 5a irq 0", rd, irq);
      end
   endtask

   initial begin
      test_reset();
      test_pins_drive();
      test_set_clr_tgl();
      test_unmapped();
      test_rise_irq();
      test_fall_vs_clear();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
